// File: rtl/padding_writer_ctrl_if.sv
// Handshake, config and buffer-write bundle for padding_writer_ctrl.
// Defining PADDING_WRITER_ASYM_EN adds cfg_pad_br for bottom/right padding.
interface padding_writer_ctrl_if #(
  parameter int PE     = 16,
  parameter int ELEM_W = 8,
  parameter int DIM_W  = 11,
  parameter int ADDR_W = 32
);
  localparam int DATA_W = PE * ELEM_W;

  logic              start;
  logic [DIM_W-1:0]  cfg_h;
  logic [DIM_W-1:0]  cfg_w;
  logic [DIM_W-1:0]  cfg_c;
  logic [1:0]        cfg_pad;
`ifdef PADDING_WRITER_ASYM_EN
  logic [1:0]        cfg_pad_br;
`endif
  logic [ADDR_W-1:0] cfg_base;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              row_done;
  logic              busy;
  logic              done;

  modport master (
`ifdef PADDING_WRITER_ASYM_EN
    output cfg_pad_br,
`endif
    output start, cfg_h, cfg_w, cfg_c, cfg_pad, cfg_base, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, row_done, busy, done
  );

  modport slave (
`ifdef PADDING_WRITER_ASYM_EN
    input  cfg_pad_br,
`endif
    input  start, cfg_h, cfg_w, cfg_c, cfg_pad, cfg_base, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, row_done, busy, done
  );
endinterface

// File: rtl/padding_writer_ctrl.sv
// Streaming zero-padding writer: walks the padded tensor (g, x, y) writing zeros or input words.
// 1-cycle input-to-write latency; stalls only on interior positions. PADDING_WRITER_ASYM_EN: asymmetric pad.
module padding_writer_ctrl #(
  parameter int PE      = 16,
  parameter int ELEM_W  = 8,
  parameter int DIM_W   = 11,
  parameter int PAD_MAX = 3,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  padding_writer_ctrl_if.slave bus
);
  localparam int DATA_W = PE * ELEM_W;
  localparam int CNT_W  = DIM_W + 2;
  localparam logic [DIM_W-1:0] PE_D      = DIM_W'(PE);
  localparam logic [1:0]       PAD_MAX_V = 2'(PAD_MAX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [1:0]        w_pad_tl, w_pad_br;
  logic [DIM_W-1:0]  w_cw;
  logic              w_cfg_empty;

  logic [CNT_W-1:0]  r_cw_last, r_pw_last, r_ph_last;
  logic [CNT_W-1:0]  r_pad_tl, r_x_hi, r_y_hi;
  logic [ADDR_W-1:0] r_base, r_lin;
  logic [CNT_W-1:0]  r_g, r_x, r_y;
  logic              r_fin;
  logic              r_wr_en, r_row_done;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic w_interior, w_run, w_step;
  logic w_g_last, w_x_last, w_y_last, w_last;

  assign w_pad_tl = (bus.cfg_pad > PAD_MAX_V) ? PAD_MAX_V : bus.cfg_pad;
`ifdef PADDING_WRITER_ASYM_EN
  assign w_pad_br = (bus.cfg_pad_br > PAD_MAX_V) ? PAD_MAX_V : bus.cfg_pad_br;
`else
  assign w_pad_br = w_pad_tl;
`endif
  assign w_cw        = bus.cfg_c / PE_D;
  assign w_cfg_empty = (w_cw == '0) || (bus.cfg_w == '0) || (bus.cfg_h == '0);

  assign w_interior = (r_x >= r_pad_tl) && (r_x < r_x_hi) &&
                      (r_y >= r_pad_tl) && (r_y < r_y_hi);
  // r_fin blocks any step between the final write and the move to DONE
  assign w_run    = (r_state == S_RUN) && !r_fin;
  assign w_step   = w_run && (!w_interior || bus.in_valid);
  assign w_g_last = (r_g == r_cw_last);
  assign w_x_last = (r_x == r_pw_last);
  assign w_y_last = (r_y == r_ph_last);
  assign w_last   = w_g_last && w_x_last && w_y_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = w_cfg_empty ? S_DONE : S_RUN;
      S_RUN:  if (r_fin)     w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = w_run && w_interior;
    bus.busy     = (r_state != S_IDLE);
    bus.done     = (r_state == S_DONE);
    bus.wr_en    = r_wr_en;
    bus.wr_addr  = r_wr_addr;
    bus.wr_data  = r_wr_data;
    bus.row_done = r_row_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cw_last  <= '0;
      r_pw_last  <= '0;
      r_ph_last  <= '0;
      r_pad_tl   <= '0;
      r_x_hi     <= '0;
      r_y_hi     <= '0;
      r_base     <= '0;
      r_lin      <= '0;
      r_g        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_fin      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_row_done <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en    <= w_step;
      r_row_done <= w_step && w_g_last && w_x_last;
      if (w_step) begin
        r_wr_addr <= r_base + r_lin;
        r_wr_data <= w_interior ? bus.in_data : '0;
      end

      if ((r_state == S_IDLE) && bus.start) begin
        r_cw_last <= CNT_W'(w_cw) - CNT_W'(1);
        r_pw_last <= CNT_W'(bus.cfg_w) + CNT_W'(w_pad_tl) + CNT_W'(w_pad_br) - CNT_W'(1);
        r_ph_last <= CNT_W'(bus.cfg_h) + CNT_W'(w_pad_tl) + CNT_W'(w_pad_br) - CNT_W'(1);
        r_pad_tl  <= CNT_W'(w_pad_tl);
        r_x_hi    <= CNT_W'(w_pad_tl) + CNT_W'(bus.cfg_w);
        r_y_hi    <= CNT_W'(w_pad_tl) + CNT_W'(bus.cfg_h);
        r_base    <= bus.cfg_base;
        r_lin     <= '0;
        r_g       <= '0;
        r_x       <= '0;
        r_y       <= '0;
        r_fin     <= 1'b0;
      end else if (w_step) begin
        r_lin <= r_lin + ADDR_W'(1);
        if (w_last) r_fin <= 1'b1;
        // g fastest, then x, then y
        if (!w_g_last) begin
          r_g <= r_g + CNT_W'(1);
        end else begin
          r_g <= '0;
          if (!w_x_last) begin
            r_x <= r_x + CNT_W'(1);
          end else begin
            r_x <= '0;
            r_y <= w_y_last ? '0 : r_y + CNT_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: doc/padding_writer_ctrl.md
Name: padding_writer_ctrl

Overview:
- Streaming zero-padding writer for the fused-layer path.
- Consumes one layer's OFM as PE-channel words in raster order (row, column, channel-group) and writes a fully padded tensor into the next layer's IFM buffer.
- Pad positions are written with zeros without waiting for input. Interior positions write input words in order.
- Generalised over PE width, element width, padding size and base address. Adds valid/ready backpressure and per-row completion pulses for the downstream line pipeline.

Parameters:
- PE, 16, channels per word.
- ELEM_W, 8, bits per channel element; word width DATA_W = PE*ELEM_W.
- DIM_W, 11, width of cfg_h/cfg_w/cfg_c.
- PAD_MAX, 3, largest legal padding.
- ADDR_W, 32, write address width.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- start, in, 1, one-cycle launch pulse; sampled only in IDLE.
- cfg_h, in, DIM_W, unpadded height.
- cfg_w, in, DIM_W, unpadded width.
- cfg_c, in, DIM_W, channels; must be a multiple of PE.
- cfg_pad, in, 2, padding on all sides (top/left only when PADDING_WRITER_ASYM_EN is defined); legal range 0..PAD_MAX.
- cfg_base, in, ADDR_W, buffer address of the first padded word.
- in_valid, in, 1, input word valid.
- in_ready, out, 1, input accepted when in_valid && in_ready.
- in_data, in, DATA_W, input word.
- wr_en, out, 1, buffer write strobe.
- wr_addr, out, ADDR_W, write address.
- wr_data, out, DATA_W, write data.
- row_done, out, 1, pulses together with the last write of each padded row.
- busy, out, 1, high in RUN and DONE.
- done, out, 1, one-cycle completion pulse.

Behaviour:
- Reset: state IDLE; all outputs 0; all counters 0.
- Config latching: cfg_* are latched on start in IDLE. CW = cfg_c/PE, PW = cfg_w + 2*pad, PH = cfg_h + 2*pad. Changes to cfg_* during RUN are ignored.
- Counters: g (0..CW-1), x (0..PW-1), y (0..PH-1), all DIM_W+2 bits. Linear offset lin is ADDR_W bits and wraps modulo 2^ADDR_W.
- Interior test: pad <= x < pad+cfg_w and pad <= y < pad+cfg_h.
- States:
  - IDLE -> RUN on start.
  - IDLE -> DONE on start when CW, cfg_w or cfg_h is 0; no writes are issued.
  - RUN -> DONE after the write at g=CW-1, x=PW-1, y=PH-1.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 during DONE.
  - start while not in IDLE is ignored.
- in_ready: combinational, = (state==RUN) && interior.
- Step condition in RUN: a position "steps" when it is a pad position (unconditionally) or an interior position with in_valid && in_ready.
- On a step:
  - Next cycle: wr_en=1, wr_addr=cfg_base+lin, wr_data = in_data for interior, 0 for pad.
  - Then lin+1, and g/x/y advance with g fastest, then x, then y.
  - If the position is interior and in_valid=0: counters hold and wr_en=0 next cycle.
- Latency: 1 cycle from accepted input to wr_en. Throughput is one write per cycle with no bubbles at row or pad boundaries.
- row_done=1 in the same cycle as the write for g=CW-1, x=PW-1.
- Words accepted = CW*cfg_w*cfg_h exactly. Words written = CW*PW*PH exactly.
- Reset mid-operation: immediate return to IDLE, outputs 0, no further writes.
- Illegal cfg_pad > PAD_MAX: clamped to PAD_MAX at latch.

Optional Feature:
- Macro: PADDING_WRITER_ASYM_EN.
- Defined: adds input cfg_pad_br[1:0], latched on start. Top/left padding = cfg_pad; bottom/right padding = cfg_pad_br. PW = cfg_w + pad_tl + pad_br; PH likewise. Interior upper bounds use pad_tl + cfg_w and pad_tl + cfg_h. This supports stride-2 "same" padding.
- Undefined: port absent; symmetric padding as above.

Test Plan:
1. H=W=2, C=16, pad=1, base=0, in_valid held 1 -> 16 writes at addrs 0..15. Input words land at 5,6,9,10; all others are 0. row_done on addrs 3,7,11,15. done 1 cycle after addr 15.
2. H=2, W=3, C=32, pad=0, base=0x100 -> 12 writes at 0x100..0x10B equal to the input sequence. in_ready stays high throughout RUN.
3. Case 1 with in_valid toggling every cycle -> identical addr/data sequence. Pad writes never stall; wr_en gaps only at interior positions.
4. cfg_w=0, start -> no wr_en, done pulse 1 cycle after start, busy high for 1 cycle.
5. Case 1, rst_n low after the 5th write, then restart -> all outputs 0 during reset. The rerun produces the full case-1 sequence.
6. (ASYM_EN) H=W=2, C=16, pad=0, pad_br=1 -> 9 writes. Data at addrs 0,1,3,4; zeros at 2,5,6,7,8.
